// File: rtl/pipeline_credit_rx_pkg.sv
// Shared widths, default parameter values and pointer helper for the credit receiver.
package pipeline_credit_rx_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int LATENCY_DEF = 3;
  localparam int DEPTH_DEF   = 5;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int COUNT_W = count_width(DEPTH_DEF);
  localparam int PTR_W   = ptr_width(DEPTH_DEF);

  // Non-power-of-two depths need the explicit wrap rather than natural overflow.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/pipeline_credit_rx_if.sv
// Handshake bundle between the credit receiver, its upstream, the pipeline and downstream.
interface pipeline_credit_rx_if #(
  parameter int WIDTH = 8
);
  logic             _i_up_valid;
  logic             _o_up_ready;
  logic             _o_launch;
  logic [WIDTH-1:0] _i_pipe_data;
  logic             _o_down_valid;
  logic [WIDTH-1:0] _o_down_data;
  logic             _i_down_ready;
  logic             _o_overflow;

  modport master (
    output _i_up_valid, _i_pipe_data, _i_down_ready,
    input  _o_up_ready, _o_launch, _o_down_valid, _o_down_data, _o_overflow
  );

  modport slave (
    input  _i_up_valid, _i_pipe_data, _i_down_ready,
    output _o_up_ready, _o_launch, _o_down_valid, _o_down_data, _o_overflow
  );
endinterface

// File: rtl/pipeline_credit_rx_fifo.sv
// Capture FIFO: DEPTH entries, push/pop in the same cycle at any occupancy, no bypass.
// Latency: a push is visible on valid/head one cycle later. Backpressure: none; a push while full is dropped and flagged.
// Overflow flag is sticky until reset.
module pipeline_credit_fifo
  import pipeline_credit_rx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             _i_clk,
  input  logic             _i_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic             overflow
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic             overflow_q, overflow_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop && (occ_q != '0);
    // When full, a simultaneous pop frees the slot the write lands in.
    do_push = push && ((occ_q != FULL) || do_pop);

    rd_ptr_d = do_pop  ? PW'(ptr_inc(32'(rd_ptr_q), DEPTH)) : rd_ptr_q;
    wr_ptr_d = do_push ? PW'(ptr_inc(32'(wr_ptr_q), DEPTH)) : wr_ptr_q;

    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase

    overflow_d = overflow_q || (push && (occ_q == FULL) && !do_pop);
  end

  always_ff @(posedge _i_clk) begin
    if (_i_rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge _i_clk) begin
    if (do_push && !_i_rst) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign valid    = (occ_q != '0);
  assign head     = mem_q[rd_ptr_q];
  assign overflow = overflow_q;

endmodule

// File: rtl/pipeline_credit_rx.sv
// Receiving end of a fixed-latency pipeline: issues credit-limited launches and queues the results.
// Latency: launch to down_valid is LATENCY+1 cycles minimum; one item per cycle sustained.
// Backpressure: down_ready low holds the FIFO; up_ready drops once DEPTH items are outstanding.
module pipeline_credit_rx
  import pipeline_credit_rx_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int LATENCY = LATENCY_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                 _i_clk,
  input  logic                 _i_rst,
  pipeline_credit_rx_if.slave  bus
);

  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [LATENCY-1:0] track_q, track_d;
  logic [CW-1:0]      count_q, count_d;
  logic               up_ready, launch, pop, capture;
  logic               fifo_valid;
  logic [WIDTH-1:0]   fifo_head;
  logic               fifo_overflow;

  always_comb begin
    // Credit decision uses only registered count, so down_ready never reaches up_ready.
    up_ready = !_i_rst && (count_q < FULL);
    launch   = bus._i_up_valid && up_ready;
    pop      = fifo_valid && bus._i_down_ready;
    capture  = track_q[LATENCY-1];
    track_d  = LATENCY'({track_q, launch});
    count_d  = count_q + CW'(launch) - CW'(pop);
  end

  always_ff @(posedge _i_clk) begin
    if (_i_rst) begin
      track_q <= '0;
      count_q <= '0;
    end else begin
      track_q <= track_d;
      count_q <= count_d;
    end
  end

  pipeline_credit_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    ._i_clk    (_i_clk),
    ._i_rst    (_i_rst),
    .push      (capture),
    .push_data (bus._i_pipe_data),
    .pop       (pop),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .overflow  (fifo_overflow)
  );

  assign bus._o_up_ready   = up_ready;
  assign bus._o_launch     = launch;
  assign bus._o_down_valid = fifo_valid;
  assign bus._o_down_data  = fifo_head;
  assign bus._o_overflow   = fifo_overflow;

endmodule

// File: tb/tb_pipeline_credit_rx.sv
// Directed bench: models the pipeline as a 3-cycle delay of launch data and checks handshake timing and order.
module tb_pipeline_credit_rx;

  logic       clk;
  logic       rst;
  logic [7:0] up_data;
  logic [7:0] pipe_sr [3];

  int n_assert = 0;
  int n_fail   = 0;

  pipeline_credit_rx_if #(.WIDTH(8)) bus ();

  pipeline_credit_rx #(
    .WIDTH   (8),
    .LATENCY (3),
    .DEPTH   (5)
  ) dut (
    ._i_clk (clk),
    ._i_rst (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pipeline model: non-stallable, launch data reappears 3 cycles later; idle slots carry junk.
  always @(posedge clk) begin
    pipe_sr[0] <= bus._o_launch ? up_data : 8'hEE;
    pipe_sr[1] <= pipe_sr[0];
    pipe_sr[2] <= pipe_sr[1];
  end
  assign bus._i_pipe_data = pipe_sr[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int launched;
    int popped;
    int n_launch;

    // 1. reset with upstream requesting
    rst = 1'b1;
    bus._i_up_valid   = 1'b1;
    bus._i_down_ready = 1'b0;
    up_data = 8'h00;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst_up_ready", bus._o_up_ready, 0);
      chk("rst_launch", bus._o_launch, 0);
      step();
    end
    rst = 1'b0;
    bus._i_up_valid = 1'b0;
    #1;
    chk("rel_up_ready", bus._o_up_ready, 1);
    chk("rel_down_valid", bus._o_down_valid, 0);
    chk("rel_overflow", bus._o_overflow, 0);
    step();

    // 2. single item, launch-to-valid is 4 cycles
    bus._i_up_valid   = 1'b1;
    bus._i_down_ready = 1'b1;
    up_data = 8'h01;
    #1;
    chk("single_launch", bus._o_launch, 1);
    step();
    bus._i_up_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk("single_early", bus._o_down_valid, 0);
      step();
    end
    #1;
    chk("single_valid", bus._o_down_valid, 1);
    chk("single_data", bus._o_down_data, 8'h01);
    step();
    #1;
    chk("single_gone", bus._o_down_valid, 0);

    // 3. streaming 10 items at full rate
    for (int k = 0; k < 15; k++) begin
      bus._i_up_valid = (k < 10);
      up_data = 8'(8'h10 + k);
      #1;
      if (k < 10) chk("stream_up_ready", bus._o_up_ready, 1);
      chk("stream_valid", bus._o_down_valid, (k >= 4 && k < 14) ? 1 : 0);
      if (k >= 4 && k < 14) chk("stream_data", bus._o_down_data, 8'h10 + k - 4);
      step();
    end

    // 4. backpressure: exactly DEPTH credits
    bus._i_down_ready = 1'b0;
    bus._i_up_valid   = 1'b1;
    n_launch = 0;
    for (int k = 0; k < 10; k++) begin
      up_data = 8'(8'h30 + k);
      #1;
      chk("bp_launch", bus._o_launch, (k < 5) ? 1 : 0);
      if (bus._o_launch) n_launch++;
      step();
    end
    chk("bp_launch_count", n_launch, 5);
    bus._i_up_valid   = 1'b0;
    bus._i_down_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_up_ready", bus._o_up_ready, (k == 0) ? 0 : 1);
      chk("bp_valid", bus._o_down_valid, 1);
      chk("bp_data", bus._o_down_data, 8'h30 + k);
      step();
    end
    #1;
    chk("bp_drained", bus._o_down_valid, 0);
    chk("bp_overflow", bus._o_overflow, 0);

    // 5. pointer wrap with ready pattern 1,0,0,1
    launched = 0;
    popped   = 0;
    for (int k = 0; k < 80 && popped < 12; k++) begin
      bus._i_up_valid   = (launched < 12);
      up_data           = 8'(32'h20 + launched);
      bus._i_down_ready = ((k % 4) == 0) || ((k % 4) == 3);
      #1;
      if (bus._o_down_valid) begin
        chk("wrap_data", bus._o_down_data, 32'h20 + popped);
        if (bus._i_down_ready) popped++;
      end
      if (bus._o_launch) launched++;
      step();
    end
    chk("wrap_popped", popped, 12);
    #1;
    chk("wrap_overflow", bus._o_overflow, 0);

    // 6. reset with 3 in flight and 2 stored
    bus._i_down_ready = 1'b0;
    bus._i_up_valid   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      up_data = 8'(8'h40 + k);
      #1;
      chk("mid_launch", bus._o_launch, 1);
      step();
    end
    bus._i_up_valid = 1'b0;
    #1;
    chk("mid_stored", bus._o_down_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_up_ready", bus._o_up_ready, 0);
    step();
    rst = 1'b0;
    bus._i_down_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus._i_up_valid = (k < 5);
      up_data = 8'(8'h50 + k);
      #1;
      if (k < 5) chk("mid_relaunch", bus._o_launch, 1);
      chk("mid_valid", bus._o_down_valid, (k >= 4 && k < 9) ? 1 : 0);
      if (k >= 4 && k < 9) chk("mid_data", bus._o_down_data, 8'h50 + k - 4);
      step();
    end
    #1;
    chk("mid_overflow", bus._o_overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
